// File: rtl/latch_bank_wr_seq_pkg.sv
// Shared types and constants for the latch-bank write sequencer.
package latch_bank_wr_seq_pkg;

    // Pulse/clear width counter is 4 bits, enough for widths of 1..15 cycles.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    // Counter load value for a width of cyc cycles; terminal count fires at zero.
    function automatic logic [CNT_W-1:0] pulse_load(input int unsigned cyc);
        return CNT_W'(cyc - 32'd1);
    endfunction

endpackage

// File: rtl/latch_bank_wr_cnt.sv
// Loadable down-counter timing the latch-enable and latch-clear widths.
module latch_bank_wr_cnt
    import latch_bank_wr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_c,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_c,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_c) begin
            cnt_d = load_val;
        end else if (dec_c && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_wr_seq.sv
// Write sequencer for a bank of level-sensitive latches: D setup, E pulse, D hold, and bank clear.
module latch_bank_wr_seq
    import latch_bank_wr_seq_pkg::*;
#(
    parameter int unsigned WORDS     = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_CYC = 1
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [$clog2(WORDS)-1:0] REQ_ADDR,
    input  logic [WIDTH-1:0]         REQ_DATA,
    input  logic                     CLR_REQ,
    output logic [WIDTH-1:0]         LAT_D,
    output logic [WORDS-1:0]         LAT_E,
    output logic                     LAT_RN,
    output logic                     WR_DONE,
    output logic                     ADDR_ERR
);

    localparam int unsigned AW = $clog2(WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = pulse_load(PULSE_CYC);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [WORDS-1:0] lat_e_q, lat_e_d;
    logic             lat_rn_q, lat_rn_d;
    logic             wr_done_q, wr_done_d;
    logic             addr_err_q, addr_err_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             addr_ok_q, addr_ok_d;
    logic             live_q, live_d;

    logic             cnt_load_c;
    logic             cnt_dec_c;
    logic             cnt_tc_c;
    logic             in_range_c;
    logic             ready_c;

    // Width timer shared by the enable pulse and the clear pulse.
    latch_bank_wr_cnt u_cnt (
        .clk      (CLK),
        .rst_n    (RN),
        .load_c   (cnt_load_c),
        .load_val (CNT_LOAD),
        .dec_c    (cnt_dec_c),
        .tc_c     (cnt_tc_c)
    );

    // Next state and next registered outputs; live_q holds off all activity for the first edge after reset.
    always_comb begin
        state_d    = state_q;
        lat_d_d    = lat_d_q;
        lat_e_d    = '0;
        lat_rn_d   = 1'b1;
        wr_done_d  = 1'b0;
        addr_err_d = 1'b0;
        addr_d     = addr_q;
        addr_ok_d  = addr_ok_q;
        live_d     = 1'b1;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        in_range_c = (32'(REQ_ADDR) < WORDS);
        ready_c    = (state_q == ST_IDLE) && live_q && !CLR_REQ;

        case (state_q)
            ST_IDLE: begin
                if (live_q) begin
                    if (CLR_REQ) begin
                        state_d    = ST_CLEAR;
                        lat_rn_d   = 1'b0;
                        cnt_load_c = 1'b1;
                    end else if (REQ_VALID) begin
                        state_d    = ST_SETUP;
                        lat_d_d    = REQ_DATA;
                        addr_d     = REQ_ADDR;
                        addr_ok_d  = in_range_c;
                        addr_err_d = !in_range_c;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_PULSE;
                cnt_load_c = 1'b1;
                if (addr_ok_q) begin
                    lat_e_d = WORDS'(1) << addr_q;
                end
            end
            ST_PULSE: begin
                if (cnt_tc_c) begin
                    state_d = ST_HOLD;
                end else begin
                    lat_e_d   = lat_e_q;
                    cnt_dec_c = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d   = ST_IDLE;
                wr_done_d = 1'b1;
            end
            ST_CLEAR: begin
                if (cnt_tc_c) begin
                    state_d   = ST_IDLE;
                    wr_done_d = 1'b1;
                end else begin
                    lat_rn_d  = 1'b0;
                    cnt_dec_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the enables and clears the bank immediately.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= ST_IDLE;
            lat_d_q    <= '0;
            lat_e_q    <= '0;
            lat_rn_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
            addr_q     <= '0;
            addr_ok_q  <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_d_q    <= lat_d_d;
            lat_e_q    <= lat_e_d;
            lat_rn_q   <= lat_rn_d;
            wr_done_q  <= wr_done_d;
            addr_err_q <= addr_err_d;
            addr_q     <= addr_d;
            addr_ok_q  <= addr_ok_d;
            live_q     <= live_d;
        end
    end

    assign REQ_READY = ready_c;
    assign LAT_D     = lat_d_q;
    assign LAT_E     = lat_e_q;
    assign LAT_RN    = lat_rn_q;
    assign WR_DONE   = wr_done_q;
    assign ADDR_ERR  = addr_err_q;

endmodule

// File: tb/tb_latch_bank_wr_seq.sv
// Bench: two sequencers (6 words / 1-cycle pulse, 8 words / 4-cycle pulse) share stimulus and are
// compared every cycle against a timeline model: a write occupies P+2 cycles with E high on
// cycles 1..P after acceptance; a clear holds RN low for P cycles from its start.
module tb_latch_bank_wr_seq;

    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_CLR  = 2;

    logic       clk = 1'b0;
    logic       rn;
    logic       req_valid;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       clr_req;

    logic       a_ready, a_rn, a_done, a_err;
    logic [7:0] a_d;
    logic [5:0] a_e;
    logic       b_ready, b_rn, b_done, b_err;
    logic [7:0] b_d;
    logic [7:0] b_e;

    logic [31:0] o_ready [2];
    logic [31:0] o_d     [2];
    logic [31:0] o_e     [2];
    logic [31:0] o_rn    [2];
    logic [31:0] o_done  [2];
    logic [31:0] o_err   [2];

    int pcyc  [2] = '{1, 4};
    int words [2] = '{6, 8};

    // Reference timeline per instance.
    int       kind [2];
    int       tt   [2];
    int       ma   [2];
    logic [7:0] md [2];
    logic     live [2];
    logic     done [2];
    logic     acc  [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    latch_bank_wr_seq #(.WORDS(6), .WIDTH(8), .PULSE_CYC(1)) u_a (
        .CLK(clk), .RN(rn), .REQ_VALID(req_valid), .REQ_READY(a_ready),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .CLR_REQ(clr_req),
        .LAT_D(a_d), .LAT_E(a_e), .LAT_RN(a_rn), .WR_DONE(a_done), .ADDR_ERR(a_err)
    );

    latch_bank_wr_seq #(.WORDS(8), .WIDTH(8), .PULSE_CYC(4)) u_b (
        .CLK(clk), .RN(rn), .REQ_VALID(req_valid), .REQ_READY(b_ready),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .CLR_REQ(clr_req),
        .LAT_D(b_d), .LAT_E(b_e), .LAT_RN(b_rn), .WR_DONE(b_done), .ADDR_ERR(b_err)
    );

    assign o_ready[0] = 32'(a_ready);
    assign o_d[0]     = 32'(a_d);
    assign o_e[0]     = 32'(a_e);
    assign o_rn[0]    = 32'(a_rn);
    assign o_done[0]  = 32'(a_done);
    assign o_err[0]   = 32'(a_err);
    assign o_ready[1] = 32'(b_ready);
    assign o_d[1]     = 32'(b_d);
    assign o_e[1]     = 32'(b_e);
    assign o_rn[1]    = 32'(b_rn);
    assign o_done[1]  = 32'(b_done);
    assign o_err[1]   = 32'(b_err);

    task automatic chk(input int inst, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL u%0d %s: observed 0x%0h expected 0x%0h (cycle %0d)", inst, tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            kind[i] = K_IDLE; tt[i] = 0; ma[i] = 0; md[i] = 8'h00;
            live[i] = 1'b0; done[i] = 1'b0; acc[i] = 1'b0;
        end
    endtask

    // Advance the timeline by one rising edge using the inputs present at that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            done[i] = 1'b0;
            acc[i]  = 1'b0;
            if (rn) begin
                if (!live[i]) begin
                    live[i] = 1'b1;
                end else if (kind[i] == K_IDLE) begin
                    if (clr_req) begin
                        kind[i] = K_CLR; tt[i] = 0;
                    end else if (req_valid) begin
                        kind[i] = K_WR; tt[i] = 0;
                        ma[i] = int'(req_addr); md[i] = req_data; acc[i] = 1'b1;
                    end
                end else begin
                    tt[i]++;
                    if ((kind[i] == K_WR && tt[i] == pcyc[i] + 2) ||
                        (kind[i] == K_CLR && tt[i] == pcyc[i])) begin
                        kind[i] = K_IDLE; done[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_e;
        logic        exp_rdy;
        logic        exp_rn;
        for (int i = 0; i < 2; i++) begin
            exp_e = '0;
            if (kind[i] == K_WR && tt[i] >= 1 && tt[i] <= pcyc[i] && ma[i] < words[i])
                exp_e = 32'd1 << ma[i];
            exp_rdy = rn && live[i] && (kind[i] == K_IDLE) && !clr_req;
            exp_rn  = live[i] && (kind[i] != K_CLR);
            chk(i, "lat_d", o_d[i], 32'(md[i]));
            chk(i, "lat_e", o_e[i], exp_e);
            chk(i, "lat_rn", o_rn[i], 32'(exp_rn));
            chk(i, "wr_done", o_done[i], 32'(done[i]));
            chk(i, "addr_err", o_err[i], 32'(acc[i] && (ma[i] >= words[i])));
            chk(i, "req_ready", o_ready[i], 32'(exp_rdy));
            chk(i, "e_while_clr", 32'((o_rn[i] == 0) && (o_e[i] != 0)), 32'd0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(kind[0] == K_IDLE && kind[1] == K_IDLE && live[0] && live[1]) && k < 40) begin
            cycle();
            k++;
        end
        chk(-1, "idle_wait_expired", 32'(k >= 40), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int first, second, ready_rise, e_cyc, start, a_low, b_low, a_acc, b_acc, dn;

        // Reset state held across edges.
        rn = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; clr_req = 1'b0;
        model_reset();
        #2;
        check_all();
        cycle();
        cycle();
        rn = 1'b1;
        cycle();
        chk(0, "post_rst_rn", o_rn[0], 32'd1);
        chk(1, "post_rst_ready", o_ready[1], 32'd1);

        // Basic write: addr 3, data 0xA5 on the 1-cycle instance.
        req_valid = 1'b1; req_addr = 3'd3; req_data = 8'hA5;
        cycle();
        req_valid = 1'b0; req_data = 8'h5A;
        chk(0, "basic_d_acc", o_d[0], 32'h0000_00A5);
        chk(0, "basic_e_setup", o_e[0], 32'd0);
        cycle();
        chk(0, "basic_e_pulse", o_e[0], 32'h0000_0008);
        cycle();
        chk(0, "basic_e_hold", o_e[0], 32'd0);
        chk(0, "basic_d_hold", o_d[0], 32'h0000_00A5);
        cycle();
        chk(0, "basic_done", o_done[0], 32'd1);
        wait_idle();

        // Back-to-back requests held valid on the 4-cycle instance.
        req_valid = 1'b1; req_addr = 3'd2; req_data = 8'h3C;
        first = -1; second = -1; ready_rise = -1; e_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (o_e[1] != 0) e_cyc++;
            if (first >= 0 && second < 0 && (cyc - first) <= 6)
                chk(1, "b2b_d_stable", o_d[1], 32'h0000_003C);
            if (acc[1]) begin
                if (first < 0) begin
                    first = cyc; req_addr = 3'd5; req_data = 8'hC3;
                end else if (second < 0) begin
                    second = cyc; req_valid = 1'b0;
                end
            end else if (first >= 0 && second < 0 && ready_rise < 0 && o_ready[1] == 32'd1) begin
                ready_rise = cyc;
            end
        end
        req_valid = 1'b0;
        chk(1, "b2b_ready_gap", 32'(ready_rise - first), 32'd6);
        chk(1, "b2b_accept_gap", 32'(second - first), 32'd7);
        chk(1, "b2b_e_cycles", 32'(e_cyc), 32'd8);
        wait_idle();

        // Clear and write requested together: clear wins, write follows.
        clr_req = 1'b1; req_valid = 1'b1; req_addr = 3'd1; req_data = 8'h77;
        start = -1; a_low = 0; b_low = 0; a_acc = -1; b_acc = -1;
        for (int k = 0; k < 13; k++) begin
            cycle();
            if (k == 0) begin
                start = cyc; clr_req = 1'b0;
                chk(1, "clr_no_accept", 32'(acc[1]), 32'd0);
            end
            if (o_rn[0] == 0) a_low++;
            if (o_rn[1] == 0) b_low++;
            if (acc[0] && a_acc < 0) a_acc = cyc - start;
            if (acc[1] && b_acc < 0) b_acc = cyc - start;
        end
        req_valid = 1'b0;
        chk(0, "clr_low_cycles", 32'(a_low), 32'd1);
        chk(1, "clr_low_cycles", 32'(b_low), 32'd4);
        chk(0, "clr_then_accept", 32'(a_acc), 32'd2);
        chk(1, "clr_then_accept", 32'(b_acc), 32'd5);
        wait_idle();

        // Out-of-range address 7 on the 6-word instance.
        req_valid = 1'b1; req_addr = 3'd7; req_data = 8'h11;
        cycle();
        req_valid = 1'b0;
        chk(0, "oor_err", o_err[0], 32'd1);
        chk(1, "oor_err", o_err[1], 32'd0);
        cycle();
        chk(0, "oor_e", o_e[0], 32'd0);
        chk(1, "oor_e", o_e[1], 32'h0000_0080);
        cycle();
        chk(0, "oor_e_hold", o_e[0], 32'd0);
        cycle();
        chk(0, "oor_done", o_done[0], 32'd1);
        wait_idle();

        // Reset in the middle of the 4-cycle pulse.
        req_valid = 1'b1; req_addr = 3'd6; req_data = 8'h99;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        chk(1, "mid_e_before", o_e[1], 32'h0000_0040);
        #2;
        rn = 1'b0;
        model_reset();
        #1;
        chk(1, "mid_e_async", o_e[1], 32'd0);
        chk(1, "mid_rn_async", o_rn[1], 32'd0);
        chk(1, "mid_ready_async", o_ready[1], 32'd0);
        check_all();
        cycle();
        rn = 1'b1;
        cycle();
        chk(1, "mid_rel_rn", o_rn[1], 32'd1);
        chk(1, "mid_rel_ready", o_ready[1], 32'd1);
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (o_done[1] != 0) dn++;
        end
        chk(1, "mid_no_done", 32'(dn), 32'd0);

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if (!rn) begin
                rn = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                rn = 1'b0;
                model_reset();
                #1;
                check_all();
            end
            req_valid = 1'($urandom_range(1));
            req_addr  = 3'($urandom_range(7));
            req_data  = 8'($urandom);
            clr_req   = ($urandom_range(7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
